bus_arbiter_mux: RTL and testbench
==================================

# bus_arbiter_mux

Parametrised, registered datapath bus for the mini CPU. It replaces direct drive-enable selection with request/grant arbitration across `NSRC` sources: one-hot grant, round-robin or fixed-priority selection, a bounded bus tenure with preemption, and a bus-keeper output. It sits between the register file, HI/LO, Z, PC, MDR, InPort and C sources and every bus consumer.

## Interface
- `WIDTH`, default 32: bus data width.
- `NSRC`, default 24: number of bus sources, at least 2.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another source is waiting, at least 1.
- `IDXW`, default `$clog2(NSRC)`: width of the owner index (derived).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NSRC  per-source bus request; must be held for as long as the source wants the bus.
- `src_data`  in  NSRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
- `rr_mode`  in  1  1 = round-robin, 0 = fixed priority (highest index wins).
- `gnt`  out  NSRC  one-hot grant, registered.
- `owner`  out  IDXW  binary index of the granted source; valid when `busy` = 1.
- `busy`  out  1  a grant is active.
- `bus_out`  out  WIDTH  registered bus value; keeps its last value when there is no owner.
- `bus_valid`  out  1  `bus_out` was loaded from a granted source on the last edge.
- `preempt`  out  1  one-cycle pulse when a tenure was ended by the `MAX_HOLD` limit.

## Operation
- States: IDLE (no owner) and OWN (exactly one owner). `gnt` is always one-hot or zero.
- IDLE: if any `req` bit is high, grant the winner, move to OWN and clear `hold_cnt`. Otherwise stay in IDLE.
- OWN, owner `req` dropped: re-arbitrate in the same edge among the other requesters, so the handoff has zero bubble. If there are no other requesters, go to IDLE with `gnt` = 0.
- OWN, owner `req` still high:
  - If `hold_cnt` = MAX_HOLD-1 and any other `req` is high, grant the winner among the others and pulse `preempt`.
  - Otherwise keep the owner. `hold_cnt` increments and saturates at MAX_HOLD-1.
- Winner selection:
  - Round-robin: the first requester searching from `last+1` upward, wrapping modulo NSRC. `last` is the most recent grantee and updates on every new grant.
  - Fixed priority: the highest requesting index wins. This matches the legacy last-enable-wins bus.
  - `rr_mode` is sampled only at arbitration points.
- Datapath: every edge with a grant active, `bus_out` <= word of the owner and `bus_valid` <= 1. Every edge with no grant, `bus_out` holds and `bus_valid` <= 0.
- `hold_cnt` is `$clog2(MAX_HOLD)+1` bits wide. `owner` is the encoder output of `gnt`.

## Timing
- Reset values: `gnt` = 0, `owner` = 0, `busy` = 0, `bus_out` = 0, `bus_valid` = 0, `preempt` = 0, state IDLE, `hold_cnt` = 0, `last` = NSRC-1 (source 0 wins first in round-robin).
- Reset applied mid-tenure clears everything immediately, without waiting for a clock edge.
- Latency: `req` high before edge k gives `gnt`/`busy` at k. The granted source's data appears on `bus_out` at k+1 with `bus_valid` = 1.
- Release: owner `req` low before edge k removes the grant at k. The final owner word is the one sampled at edge k-1.
- Preemption: an owner holding through MAX_HOLD grant cycles loses the grant at the next edge if another source is requesting. `preempt` is high for exactly that one cycle.
- Simultaneous release and preempt condition: treated as a release, so `preempt` stays 0.
- A single requester holds the bus indefinitely.

## Structure
- Shared package `bus_pkg` holds the default WIDTH/NSRC and named source-index constants (R0..R15, HI, LO, ZHIGH, ZLOW, PC, MDR, INPORT, C = 0..23).
- One sub-module, `rr_pick`: combinational; takes the request vector, the start pointer, the mode bit and an exclude mask, and returns a one-hot winner plus an any-request flag.
- The state machine, counters and data register are in the top module.

## Test plan
- After reset, `req` = bit 5 -> `gnt` = 1<<5 and `owner` = 5 at the next edge; `src_data[5]` = 0xDEADBEEF on `bus_out` one edge later with `bus_valid` = 1.
- Round-robin with `req` bits 2, 7 and 20 held and MAX_HOLD = 4 -> grant sequence 2, 7, 20, 2, each tenure exactly 4 cycles, `preempt` pulsing at each switch.
- `rr_mode` = 0 with `req` bits 3 and 23 -> 23 wins. After 23 drops, 3 is granted on the same edge with no idle cycle.
- Owner 9 drops `req` with no other requester -> `gnt` = 0, `busy` = 0, `bus_valid` = 0, and `bus_out` keeps the last R9 value (0x12345678).
- `rst_n` pulsed low mid-tenure, asynchronous to `clk` -> all outputs 0 immediately. After reset, the first round-robin grant with `req` bits 0 and 1 goes to source 0.
- A single requester held for 50 cycles -> grant never lost and `preempt` never asserted.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus constants: default geometry, source-index map of the mini CPU
// datapath and the arbiter state type.
package bus_pkg;

   localparam int BUS_WIDTH = 32;
   localparam int BUS_NSRC  = 24;

   localparam int R0     = 0;
   localparam int R1     = 1;
   localparam int R2     = 2;
   localparam int R3     = 3;
   localparam int R4     = 4;
   localparam int R5     = 5;
   localparam int R6     = 6;
   localparam int R7     = 7;
   localparam int R8     = 8;
   localparam int R9     = 9;
   localparam int R10    = 10;
   localparam int R11    = 11;
   localparam int R12    = 12;
   localparam int R13    = 13;
   localparam int R14    = 14;
   localparam int R15    = 15;
   localparam int HI     = 16;
   localparam int LO     = 17;
   localparam int ZHIGH  = 18;
   localparam int ZLOW   = 19;
   localparam int PC     = 20;
   localparam int MDR    = 21;
   localparam int INPORT = 22;
   localparam int C      = 23;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } bus_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: round-robin from a start pointer, or highest
// index first; requesters in the exclude mask never win.
module rr_pick #(
   parameter int NSRC = 24,
   parameter int IDXW = $clog2(NSRC)
) (
   input  logic [NSRC-1:0] i_req,
   input  logic [IDXW-1:0] i_start,
   input  logic            i_rr_mode,
   input  logic [NSRC-1:0] i_excl,
   output logic [NSRC-1:0] o_gnt,
   output logic            o_any
);

   logic [NSRC-1:0] w_cand;

   assign w_cand = i_req & ~i_excl;
   assign o_any  = |w_cand;

   always_comb begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      o_gnt = '0;
      if (i_rr_mode) begin
         for (int i = 0; i < NSRC; i++) begin
            idx = int'(i_start) + i;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!found && w_cand[idx]) begin
               o_gnt[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end else begin
         for (int i = NSRC - 1; i >= 0; i--) begin
            if (!found && w_cand[i]) begin
               o_gnt[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered datapath bus with request/grant arbitration, bounded tenure
// with preemption and a bus keeper on the output word.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no owner, gnt = 0, bus_out keeps its last value
//   ST_OWN  | exactly one owner, hold counter tracks tenure length
module bus_arbiter_mux
   import bus_pkg::*;
#(
   parameter int WIDTH    = BUS_WIDTH,
   parameter int NSRC     = BUS_NSRC,
   parameter int MAX_HOLD = 4,
   parameter int IDXW     = $clog2(NSRC)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NSRC-1:0]       req,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic                  rr_mode,
   output logic [NSRC-1:0]       gnt,
   output logic [IDXW-1:0]       owner,
   output logic                  busy,
   output logic [WIDTH-1:0]      bus_out,
   output logic                  bus_valid,
   output logic                  preempt
);

   localparam int HW = $clog2(MAX_HOLD) + 1;

   bus_state_e       r_state;
   logic [NSRC-1:0]  r_gnt;
   logic [IDXW-1:0]  r_owner;
   logic [IDXW-1:0]  r_last;
   logic [HW-1:0]    r_hold;
   logic             r_preempt;
   logic [WIDTH-1:0] r_bus;
   logic             r_valid;

   logic [IDXW-1:0]  w_start;
   logic [NSRC-1:0]  w_win;
   logic             w_any;
   logic [IDXW-1:0]  w_win_idx;
   logic             w_owner_req;
   logic             w_hold_max;
   logic             w_take;
   logic [WIDTH-1:0] w_word;

   assign w_start = (r_last == IDXW'(NSRC - 1)) ? '0 : r_last + IDXW'(1);

   // Excluding the current grant keeps a preempted owner from re-winning.
   rr_pick #(
      .NSRC (NSRC),
      .IDXW (IDXW)
   ) u_pick (
      .i_req     (req),
      .i_start   (w_start),
      .i_rr_mode (rr_mode),
      .i_excl    (r_gnt),
      .o_gnt     (w_win),
      .o_any     (w_any)
   );

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (w_win[i]) w_win_idx = IDXW'(i);
      end
   end

   always_comb begin
      w_word = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (r_gnt[i]) w_word = src_data[i*WIDTH +: WIDTH];
      end
   end

   assign w_owner_req = |(req & r_gnt);
   assign w_hold_max  = (r_hold == HW'(MAX_HOLD - 1));
   assign w_take      = w_any && ((r_state == ST_IDLE) || !w_owner_req || w_hold_max);

   // The bus only loads while the owner still requests, so a released
   // source's last word is the one captured the edge before its release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_owner   <= '0;
         r_last    <= IDXW'(NSRC - 1);
         r_hold    <= '0;
         r_preempt <= 1'b0;
         r_bus     <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_preempt <= 1'b0;
         if (r_state == ST_OWN && w_owner_req) begin
            r_bus   <= w_word;
            r_valid <= 1'b1;
         end else begin
            r_valid <= 1'b0;
         end

         if (w_take) begin
            r_state   <= ST_OWN;
            r_gnt     <= w_win;
            r_owner   <= w_win_idx;
            r_last    <= w_win_idx;
            r_hold    <= '0;
            r_preempt <= (r_state == ST_OWN) && w_owner_req;
         end else if (r_state == ST_OWN && !w_owner_req) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_hold  <= '0;
         end else if (r_state == ST_OWN && !w_hold_max) begin
            r_hold <= r_hold + HW'(1);
         end
      end
   end

   assign gnt       = r_gnt;
   assign owner     = r_owner;
   assign busy      = (r_state == ST_OWN);
   assign bus_out   = r_bus;
   assign bus_valid = r_valid;
   assign preempt   = r_preempt;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: a per-cycle reference model plus
// hand-computed checkpoints for each scenario.
module tb_bus_arbiter_mux;

   localparam int WIDTH    = 32;
   localparam int NSRC     = 24;
   localparam int MAX_HOLD = 4;
   localparam int IDXW     = $clog2(NSRC);

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NSRC-1:0]       req = '0;
   logic [NSRC*WIDTH-1:0] src_data;
   logic                  rr_mode = 1'b1;
   logic [NSRC-1:0]       gnt;
   logic [IDXW-1:0]       owner;
   logic                  busy;
   logic [WIDTH-1:0]      bus_out;
   logic                  bus_valid;
   logic                  preempt;

   int vectors = 0;
   int miscompares = 0;

   bus_arbiter_mux #(
      .WIDTH    (WIDTH),
      .NSRC     (NSRC),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .src_data  (src_data),
      .rr_mode   (rr_mode),
      .gnt       (gnt),
      .owner     (owner),
      .busy      (busy),
      .bus_out   (bus_out),
      .bus_valid (bus_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 = none), tenure length, last grantee.
   int               m_own;
   int               m_hold;
   int               m_last;
   logic [WIDTH-1:0] m_bus;
   bit               m_valid;
   bit               m_pre;

   function automatic int pick(logic [NSRC-1:0] r, int last, bit rr, int excl);
      if (rr) begin
         for (int k = 1; k <= NSRC; k++) begin
            int i;
            i = (last + k) % NSRC;
            if (r[i] && i != excl) return i;
         end
      end else begin
         for (int i = NSRC - 1; i >= 0; i--)
            if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_own   <= -1;
         m_hold  <= 0;
         m_last  <= NSRC - 1;
         m_bus   <= '0;
         m_valid <= 1'b0;
         m_pre   <= 1'b0;
      end else begin : model_step
         int  nxt;
         bit  still;
         bit  tenure_up;
         still = 1'b0;
         if (m_own >= 0) still = req[m_own];
         tenure_up = still && (m_hold >= MAX_HOLD - 1);
         nxt = pick(req, m_last, rr_mode, m_own);

         if (still) begin
            m_bus   <= src_data[m_own*WIDTH +: WIDTH];
            m_valid <= 1'b1;
         end else begin
            m_valid <= 1'b0;
         end
         m_pre <= 1'b0;

         if (m_own < 0 || !still) begin
            // free bus or released owner: hand straight to the next requester
            m_own  <= nxt;
            m_hold <= 0;
            if (nxt >= 0) m_last <= nxt;
         end else if (tenure_up && nxt >= 0) begin
            m_own  <= nxt;
            m_last <= nxt;
            m_hold <= 0;
            m_pre  <= 1'b1;
         end else begin
            m_hold <= (m_hold + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_hold + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin : compare
         logic [NSRC-1:0] eg;
         eg = '0;
         if (m_own >= 0) eg[m_own] = 1'b1;
         chk("gnt", 64'(gnt), 64'(eg));
         chk("busy", 64'(busy), 64'(m_own >= 0));
         if (m_own >= 0) chk("owner", 64'(owner), 64'(m_own));
         chk("bus_out", 64'(bus_out), 64'(m_bus));
         chk("bus_valid", 64'(bus_valid), 64'(m_valid));
         chk("preempt", 64'(preempt), 64'(m_pre));
      end
   end

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lost;
      logic [NSRC-1:0] one;
      for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = 32'hA000_0000 + i;
      src_data[5*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
      src_data[9*WIDTH +: WIDTH] = 32'h1234_5678;

      @(negedge clk);
      chk("reset_gnt", 64'(gnt), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_bus_out", 64'(bus_out), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // first grant to source 5, data one edge later
      req = '0; req[5] = 1'b1;
      @(negedge clk);
      one = '0; one[5] = 1'b1;
      chk("first_gnt", 64'(gnt), 64'(one));
      chk("first_owner", 64'(owner), 64'(5));
      chk("first_valid", 64'(bus_valid), 64'(0));
      @(negedge clk);
      chk("first_bus", 64'(bus_out), 64'h0000_0000_DEAD_BEEF);
      chk("first_bus_valid", 64'(bus_valid), 64'(1));
      req = '0;
      @(negedge clk);
      @(negedge clk);

      // round-robin 2 / 7 / 20 with 4-cycle tenures
      pulse_reset();
      rr_mode = 1'b1;
      req = '0; req[2] = 1'b1; req[7] = 1'b1; req[20] = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 1 || c == 13) chk("rr_owner_2", 64'(owner), 64'(2));
         if (c == 5) chk("rr_owner_7", 64'(owner), 64'(7));
         if (c == 9) chk("rr_owner_20", 64'(owner), 64'(20));
         chk("rr_preempt", 64'(preempt), 64'(c == 5 || c == 9 || c == 13));
      end
      req = '0;
      @(negedge clk);
      @(negedge clk);

      // fixed priority: 23 beats 3, then zero-bubble handoff to 3
      rr_mode = 1'b0;
      req = '0; req[3] = 1'b1; req[23] = 1'b1;
      @(negedge clk);
      chk("fp_owner_23", 64'(owner), 64'(23));
      @(negedge clk);
      req[23] = 1'b0;
      @(negedge clk);
      chk("fp_owner_3", 64'(owner), 64'(3));
      chk("fp_busy", 64'(busy), 64'(1));

      // owner 9 releases with nobody waiting; keeper holds R9 word
      req = '0; req[9] = 1'b1;
      @(negedge clk);
      chk("r9_owner", 64'(owner), 64'(9));
      @(negedge clk);
      chk("r9_bus", 64'(bus_out), 64'h0000_0000_1234_5678);
      req = '0;
      src_data[9*WIDTH +: WIDTH] = 32'hFFFF_0000;
      @(negedge clk);
      chk("rel_gnt", 64'(gnt), 64'(0));
      chk("rel_busy", 64'(busy), 64'(0));
      chk("rel_valid", 64'(bus_valid), 64'(0));
      chk("rel_keep", 64'(bus_out), 64'h0000_0000_1234_5678);

      // asynchronous reset in the middle of a tenure
      rr_mode = 1'b1;
      req = '0; req[4] = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gnt", 64'(gnt), 64'(0));
      chk("arst_owner", 64'(owner), 64'(0));
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_bus", 64'(bus_out), 64'(0));
      chk("arst_valid", 64'(bus_valid), 64'(0));
      chk("arst_preempt", 64'(preempt), 64'(0));
      req = '0; req[0] = 1'b1; req[1] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_owner", 64'(owner), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(1));

      // single requester holds indefinitely
      req = '0; req[11] = 1'b1;
      @(negedge clk);
      one = '0; one[11] = 1'b1;
      lost = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (!(busy && owner == IDXW'(11) && gnt == one && !preempt)) lost++;
      end
      chk("solo_lost_cycles", 64'(lost), 64'(0));
      req = '0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
